ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RV32IM pipeline. Sits directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register. It resolves operand forwarding from the MEM and WB stages and computes single-cycle ALU/MUL results. It also runs a 32-iteration sequential divider for DIV/DIVU/REM/REMU, stalling IF/ID/EX through `stall_req_o` while the divider is busy.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alusel  in  5  operation from ID/EX: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MUL (low word), 12 DIV, 13 DIVU, 14 REM, 15 REMU; 16–31 treated as NOP
- s1data, s2data  in  32  operand values from ID/EX (register or immediate)
- rd  in  5  destination register
- regwe  in  1  destination write enable
- reg1addr, reg2addr  in  5  source register addresses
- reg1en, reg2en  in  1  source operand is a register (forwarding eligible)
- mem_rd  in  5 / mem_regwe  in  1 / mem_wdata  in  32  result currently in MEM
- wb_rd  in  5 / wb_regwe  in  1 / wb_wdata  in  32  result currently in WB
- wdata_o  out  32  result to EX/MEM
- rd_o  out  5  destination to EX/MEM
- regwe_o  out  1  write enable to EX/MEM (0 = bubble)
- stall_req_o  out  1  hold PC, IF/ID and ID/EX; EX/MEM receives a bubble

## Operation
- Forwarding, per operand N: if regNen and regNaddr != 0 and mem_regwe and mem_rd == regNaddr, use mem_wdata. Otherwise, if the same conditions hold for WB, use wb_wdata. Otherwise use sN data. MEM has priority over WB. x0 is never forwarded.
- Single-cycle ops are purely combinational: ADD/SUB wrap modulo 2^32. Shifts use op2[4:0]. SLT/SLTU yield 32'd1 or 32'd0. MUL yields the low 32 bits of the product. NOP yields wdata_o=0, regwe_o=0.
- rd_o = rd always. regwe_o = regwe, except that it is forced to 0 for NOP and during divider stall cycles.
- Divider FSM states:
  - IDLE to BUSY: when alusel ∈ {12..15}, the divisor is nonzero, and the operation is not signed overflow. The forwarded operands, op and signs are latched, and the counter is cleared.
  - BUSY: one restoring shift/subtract step per cycle. After 32 steps (counter == 31), go to DONE.
  - DONE: drive the sign-corrected result. Go to IDLE unconditionally.
- Signed ops divide absolute values. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
- Special cases are resolved combinationally in IDLE, with no stall and no FSM entry:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend (signed and unsigned).
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Operands are latched at start. Forwarding-source changes during BUSY do not affect the result.
- While rst is high: wdata_o=0, rd_o=0, regwe_o=0, stall_req_o=0. On the clock edge, state goes to IDLE and the counter and quotient/remainder registers go to 0.

## Timing
- Single-cycle ops and divider special cases: result valid in the same cycle as presentation. stall_req_o=0.
- Divide start cycle (IDLE with div op): stall_req_o=1, regwe_o=0.
- BUSY: stall_req_o=1, regwe_o=0 for all 32 cycles.
- DONE: stall_req_o=0, wdata_o = result, regwe_o = regwe. The EX/MEM register captures it on the following edge, and ID/EX advances on that same edge.
- Total: stall_req_o is high for exactly 33 consecutive cycles. The result appears in the 34th cycle after the div op is first presented.
- Back-to-back divides: DONE returns to IDLE. The next div op, presented the cycle after DONE, starts a fresh operation. The same instruction is never restarted.
- Reset asserted in BUSY or DONE: no result is produced. After rst deasserts, the FSM is in IDLE, stall_req_o=0, and the instruction at the inputs is evaluated fresh.

## Test plan
- ADD, reg1addr=5, mem_rd=5, mem_regwe=1, mem_wdata=10, wb_rd=5, wb_regwe=1, wb_wdata=99, s2data=3 -> wdata_o=13 (MEM priority). Same stimulus with reg1addr=0 -> uses s1data.
- SRA, s1data=0x80000000, s2data=0x21 -> wdata_o=0xC0000000 (shift amount 1). SLTU 1 vs 0xFFFFFFFF -> 1.
- DIV, s1data=-7, s2data=2 -> stall_req_o high for 33 cycles, then wdata_o=0xFFFFFFFD (-3) with regwe_o=1. REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU, s2data=0, s1data=0x1234 -> same cycle wdata_o=0xFFFFFFFF, stall_req_o=0. REMU -> 0x1234. DIV 0x80000000 / -1 -> 0x80000000, no stall.
- DIVU 100/7 started, then wb_wdata and mem_wdata toggled during BUSY -> result 14, unaffected. Back-to-back REMU 100/7 -> second result 2 after another 33 stall cycles.
- rst pulsed at BUSY cycle 10 -> stall_req_o=0 and regwe_o=0 while rst is high. FSM in IDLE afterwards. Reapplying DIVU 100/7 -> full 33-cycle stall, result 14.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the five-stage RV32IM pipeline.
//
// Resolves operand forwarding from MEM/WB and computes single-cycle ALU and MUL results.
// DIV/DIVU/REM/REMU run on a 32-step restoring divider. The stage holds the front of the
// pipe through stall_req_o while the divider is busy.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alusel                         operation select (0 NOP .. 15 REMU, 16-31 NOP)
//   s1data, s2data                 operand values from ID/EX
//   rd, regwe                      destination register and write enable
//   reg1addr/reg2addr, reg1en/en2  source register addresses and forwarding eligibility
//   mem_rd/mem_regwe/mem_wdata     result currently in MEM
//   wb_rd/wb_regwe/wb_wdata        result currently in WB
//   wdata_o, rd_o, regwe_o         result to EX/MEM (regwe_o = 0 is a bubble)
//   stall_req_o                    hold PC, IF/ID and ID/EX
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] s1data,
  input  logic [XLEN-1:0] s2data,
  input  logic [4:0]      rd,
  input  logic            regwe,
  input  logic [4:0]      reg1addr,
  input  logic [4:0]      reg2addr,
  input  logic            reg1en,
  input  logic            reg2en,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwe,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwe,
  input  logic [XLEN-1:0] wb_wdata,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      rd_o,
  output logic            regwe_o,
  output logic            stall_req_o
);

  localparam logic [4:0] OpAdd  = 5'd1;
  localparam logic [4:0] OpSub  = 5'd2;
  localparam logic [4:0] OpAnd  = 5'd3;
  localparam logic [4:0] OpOr   = 5'd4;
  localparam logic [4:0] OpXor  = 5'd5;
  localparam logic [4:0] OpSll  = 5'd6;
  localparam logic [4:0] OpSrl  = 5'd7;
  localparam logic [4:0] OpSra  = 5'd8;
  localparam logic [4:0] OpSlt  = 5'd9;
  localparam logic [4:0] OpSltu = 5'd10;
  localparam logic [4:0] OpMul  = 5'd11;
  localparam logic [4:0] OpDiv  = 5'd12;
  localparam logic [4:0] OpDivu = 5'd13;
  localparam logic [4:0] OpRem  = 5'd14;
  localparam logic [4:0] OpRemu = 5'd15;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_q, neg_d;

  logic [XLEN-1:0] op1, op2;
  logic [XLEN-1:0] alu_res;
  logic            alu_we;
  logic [XLEN-1:0] mul_lo;
  logic            is_div, div_signed, div_zero, div_ovf, div_start, div_rem;
  logic [XLEN-1:0] op1_abs, op2_abs;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic [XLEN-1:0] res_raw, div_res;

  // Forwarding: MEM beats WB, x0 is never forwarded.
  always_comb begin
    op1 = s1data;
    if (reg1en && (reg1addr != 5'd0) && mem_regwe && (mem_rd == reg1addr)) begin
      op1 = mem_wdata;
    end else if (reg1en && (reg1addr != 5'd0) && wb_regwe && (wb_rd == reg1addr)) begin
      op1 = wb_wdata;
    end
    op2 = s2data;
    if (reg2en && (reg2addr != 5'd0) && mem_regwe && (mem_rd == reg2addr)) begin
      op2 = mem_wdata;
    end else if (reg2en && (reg2addr != 5'd0) && wb_regwe && (wb_rd == reg2addr)) begin
      op2 = wb_wdata;
    end
  end

  assign is_div     = (alusel >= OpDiv) && (alusel <= OpRemu);
  assign div_signed = (alusel == OpDiv) || (alusel == OpRem);
  assign div_rem    = (alusel == OpRem) || (alusel == OpRemu);
  assign div_zero   = (op2 == '0);
  assign div_ovf    = div_signed && (op1 == MinNeg) && (op2 == '1);
  assign div_start  = is_div && !div_zero && !div_ovf;
  assign op1_abs    = (div_signed && op1[XLEN-1]) ? -op1 : op1;
  assign op2_abs    = (div_signed && op2[XLEN-1]) ? -op2 : op2;
  assign mul_lo     = op1 * op2;

  // Single-cycle results, including the divider special cases that never enter the FSM.
  always_comb begin
    alu_res = '0;
    alu_we  = regwe;
    case (alusel)
      OpAdd:  alu_res = op1 + op2;
      OpSub:  alu_res = op1 - op2;
      OpAnd:  alu_res = op1 & op2;
      OpOr:   alu_res = op1 | op2;
      OpXor:  alu_res = op1 ^ op2;
      OpSll:  alu_res = op1 << op2[4:0];
      OpSrl:  alu_res = op1 >> op2[4:0];
      OpSra:  alu_res = $unsigned($signed(op1) >>> op2[4:0]);
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      OpMul:  alu_res = mul_lo;
      OpDiv:  alu_res = div_zero ? '1 : MinNeg;
      OpDivu: alu_res = '1;
      OpRem:  alu_res = div_zero ? op1 : '0;
      OpRemu: alu_res = op1;
      default: begin
        alu_res = '0;
        alu_we  = 1'b0;
      end
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign res_raw   = is_rem_q ? rem_q : quo_q;
  assign div_res   = neg_q ? -res_raw : res_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    unique case (state_q)
      StIdle: begin
        if (div_start) begin
          state_d  = StBusy;
          cnt_d    = 5'd0;
          quo_d    = op1_abs;
          rem_d    = '0;
          dvsr_d   = op2_abs;
          is_rem_d = div_rem;
          // Quotient is negative on sign mismatch; remainder follows the dividend.
          neg_d    = div_signed && (div_rem ? op1[XLEN-1] : (op1[XLEN-1] ^ op2[XLEN-1]));
        end
      end
      StBusy: begin
        if (!rem_diff[XLEN]) begin
          rem_d = rem_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wdata_o     = alu_res;
    rd_o        = rd;
    regwe_o     = alu_we;
    stall_req_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (div_start) begin
          wdata_o     = '0;
          regwe_o     = 1'b0;
          stall_req_o = 1'b1;
        end
      end
      StBusy: begin
        wdata_o     = '0;
        regwe_o     = 1'b0;
        stall_req_o = 1'b1;
      end
      StDone: begin
        wdata_o = div_res;
        regwe_o = regwe;
      end
      default: ;
    endcase
    if (rst) begin
      wdata_o     = '0;
      rd_o        = 5'd0;
      regwe_o     = 1'b0;
      stall_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ops against a
// behavioural model, and hand-written divider sequences (forwarding changes, back-to-back,
// reset mid-divide).
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alusel;
  logic [31:0] s1data, s2data;
  logic [4:0]  rd;
  logic        regwe;
  logic [4:0]  reg1addr, reg2addr;
  logic        reg1en, reg2en;
  logic [4:0]  mem_rd;
  logic        mem_regwe;
  logic [31:0] mem_wdata;
  logic [4:0]  wb_rd;
  logic        wb_regwe;
  logic [31:0] wb_wdata;
  logic [31:0] wdata_o;
  logic [4:0]  rd_o;
  logic        regwe_o;
  logic        stall_req_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alusel     (alusel),
    .s1data     (s1data),
    .s2data     (s2data),
    .rd         (rd),
    .regwe      (regwe),
    .reg1addr   (reg1addr),
    .reg2addr   (reg2addr),
    .reg1en     (reg1en),
    .reg2en     (reg2en),
    .mem_rd     (mem_rd),
    .mem_regwe  (mem_regwe),
    .mem_wdata  (mem_wdata),
    .wb_rd      (wb_rd),
    .wb_regwe   (wb_regwe),
    .wb_wdata   (wb_wdata),
    .wdata_o    (wdata_o),
    .rd_o       (rd_o),
    .regwe_o    (regwe_o),
    .stall_req_o(stall_req_o)
  );

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  mrd;
    logic [31:0] mw;
    logic [4:0]  wrd;
    logic [31:0] ww;
    logic [31:0] exp_w;
    logic        exp_we;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] fwd(input logic en, input logic [4:0] addr,
                                      input logic [31:0] sdata);
    if (en && addr != 0 && mem_regwe && mem_rd == addr) return mem_wdata;
    if (en && addr != 0 && wb_regwe && wb_rd == addr) return wb_wdata;
    return sdata;
  endfunction

  // Architectural result of one instruction from its resolved operands.
  function automatic void model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic we, output logic [31:0] w, output logic owe,
                                output logic multi);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    w = 32'd0;
    owe = (sel >= 1 && sel <= 15) ? we : 1'b0;
    case (sel)
      1:  w = a + b;
      2:  w = a - b;
      3:  w = a & b;
      4:  w = a | b;
      5:  w = a ^ b;
      6:  w = a << b[4:0];
      7:  w = a >> b[4:0];
      8:  w = $unsigned($signed(a) >>> b[4:0]);
      9:  w = (sa < sb) ? 32'd1 : 32'd0;
      10: w = (a < b) ? 32'd1 : 32'd0;
      11: w = a * b;
      12: begin if (b == 0) w = 32'hFFFFFFFF; else begin q = sa / sb; w = q[31:0]; end end
      13: w = (b == 0) ? 32'hFFFFFFFF : a / b;
      14: begin if (b == 0) w = a; else begin r = sa % sb; w = r[31:0]; end end
      15: w = (b == 0) ? a : a % b;
      default: w = 32'd0;
    endcase
    multi = (sel >= 12 && sel <= 15) && (b != 0) &&
            !((sel == 12 || sel == 14) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // Inputs must already be driven just after a rising edge.
  task automatic run_check(input string name, input logic [31:0] exp_w, input logic exp_we,
                           input logic multi);
    int n, bad;
    @(negedge clk);
    if (multi) begin
      n = 0;
      bad = 0;
      while (stall_req_o === 1'b1 && n < 100) begin
        if (regwe_o !== 1'b0) bad++;
        n++;
        @(negedge clk);
      end
      chk({name, " stall_cycles"}, n, 33);
      chk({name, " regwe_in_stall"}, bad, 0);
    end else begin
      chk({name, " stall"}, {31'd0, stall_req_o}, 32'd0);
    end
    chk({name, " wdata"}, wdata_o, exp_w);
    chk({name, " regwe"}, {31'd0, regwe_o}, {31'd0, exp_we});
    chk({name, " rd"}, {27'd0, rd_o}, {27'd0, rd});
  endtask

  task automatic set_plain(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    alusel = sel; s1data = a; s2data = b;
    reg1en = 0; reg2en = 0; reg1addr = 0; reg2addr = 0;
    mem_regwe = 0; wb_regwe = 0; rd = 5'd9; regwe = 1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, ew;
    logic ewe, mul;
    int n;
    bit done;

    tbl[0]  = '{5'd1,  32'h55,       32'd3,        5, 0, 5, 32'd10, 5,  32'd99, 32'd13,       1};
    tbl[1]  = '{5'd1,  32'h55,       32'd3,        0, 0, 5, 32'd10, 5,  32'd99, 32'h58,       1};
    tbl[2]  = '{5'd8,  32'h80000000, 32'h21,       0, 0, 9, 32'd0,  10, 32'd0,  32'hC0000000, 1};
    tbl[3]  = '{5'd10, 32'd1,        32'hFFFFFFFF, 0, 0, 9, 32'd0,  10, 32'd0,  32'd1,        1};
    tbl[4]  = '{5'd9,  32'hFFFFFFFF, 32'd1,        0, 0, 9, 32'd0,  10, 32'd0,  32'd1,        1};
    tbl[5]  = '{5'd2,  32'd3,        32'd5,        0, 0, 9, 32'd0,  10, 32'd0,  32'hFFFFFFFE, 1};
    tbl[6]  = '{5'd1,  32'h55,       32'd1,        6, 0, 5, 32'd10, 6,  32'd99, 32'd100,      1};
    tbl[7]  = '{5'd11, 32'h10000,    32'h10001,    0, 0, 9, 32'd0,  10, 32'd0,  32'h10000,    1};
    tbl[8]  = '{5'd6,  32'd1,        32'h24,       0, 0, 9, 32'd0,  10, 32'd0,  32'd16,       1};
    tbl[9]  = '{5'd7,  32'h80000000, 32'd31,       0, 0, 9, 32'd0,  10, 32'd0,  32'd1,        1};
    tbl[10] = '{5'd5,  32'hF0F0,     32'h0FF0,     0, 0, 9, 32'd0,  10, 32'd0,  32'hFF00,     1};
    tbl[11] = '{5'd13, 32'h1234,     32'd0,        0, 0, 9, 32'd0,  10, 32'd0,  32'hFFFFFFFF, 1};
    tbl[12] = '{5'd15, 32'h1234,     32'd0,        0, 0, 9, 32'd0,  10, 32'd0,  32'h1234,     1};
    tbl[13] = '{5'd12, 32'h80000000, 32'hFFFFFFFF, 0, 0, 9, 32'd0,  10, 32'd0,  32'h80000000, 1};
    tbl[14] = '{5'd14, 32'h80000000, 32'hFFFFFFFF, 0, 0, 9, 32'd0,  10, 32'd0,  32'd0,        1};
    tbl[15] = '{5'd0,  32'd7,        32'd8,        0, 0, 9, 32'd0,  10, 32'd0,  32'd0,        0};
    tbl[16] = '{5'd20, 32'd7,        32'd8,        0, 0, 9, 32'd0,  10, 32'd0,  32'd0,        0};
    tbl[17] = '{5'd1,  32'd1,        32'h999,      0, 5, 5, 32'd10, 10, 32'd0,  32'd11,       1};
    tbl[18] = '{5'd1,  32'd4,        32'd4,        0, 0, 0, 32'd10, 0,  32'd20, 32'd8,        1};

    // Reset: outputs forced low regardless of the instruction presented.
    rst = 1;
    set_plain(5'd1, 32'd5, 32'd6);
    mem_rd = 0; wb_rd = 0; mem_wdata = 0; wb_wdata = 0;
    @(negedge clk);
    chk("reset wdata", wdata_o, 32'd0);
    chk("reset rd", {27'd0, rd_o}, 32'd0);
    chk("reset regwe", {31'd0, regwe_o}, 32'd0);
    chk("reset stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      alusel = tbl[i].sel; s1data = tbl[i].s1; s2data = tbl[i].s2;
      reg1addr = tbl[i].r1; reg2addr = tbl[i].r2; reg1en = 1; reg2en = 1;
      mem_rd = tbl[i].mrd; mem_regwe = 1; mem_wdata = tbl[i].mw;
      wb_rd = tbl[i].wrd; wb_regwe = 1; wb_wdata = tbl[i].ww;
      rd = 5'd7; regwe = 1;
      run_check($sformatf("vec%0d", i), tbl[i].exp_w, tbl[i].exp_we, 1'b0);
    end

    // Directed signed divide/remainder.
    @(posedge clk); #1;
    set_plain(5'd12, 32'hFFFFFFF9, 32'd2);
    run_check("div -7/2", 32'hFFFFFFFD, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_plain(5'd14, 32'hFFFFFFF9, 32'd2);
    run_check("rem -7/2", 32'hFFFFFFFF, 1'b1, 1'b1);

    // DIVU with forwarded operands; forwarding sources change while busy.
    @(posedge clk); #1;
    set_plain(5'd13, 32'hDEAD, 32'hBEEF);
    reg1en = 1; reg1addr = 5; mem_rd = 5; mem_regwe = 1; mem_wdata = 100;
    reg2en = 1; reg2addr = 6; wb_rd = 6; wb_regwe = 1; wb_wdata = 7;
    @(negedge clk);
    chk("fwd_div start stall", {31'd0, stall_req_o}, 32'd1);
    n = 1;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      mem_wdata = $urandom; wb_wdata = $urandom;
      @(negedge clk);
      if (stall_req_o) n++;
      else done = 1;
    end
    chk("fwd_div stall_cycles", n, 33);
    chk("fwd_div wdata", wdata_o, 32'd14);
    chk("fwd_div regwe", {31'd0, regwe_o}, 32'd1);

    // Back-to-back: next divide presented the cycle after DONE.
    @(posedge clk); #1;
    set_plain(5'd15, 32'd100, 32'd7);
    run_check("b2b remu", 32'd2, 1'b1, 1'b1);

    // Reset during BUSY cycle 10, then re-evaluate the same instruction.
    @(posedge clk); #1;
    set_plain(5'd13, 32'd100, 32'd7);
    @(negedge clk);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("pre_rst busy stall", {31'd0, stall_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_busy stall", {31'd0, stall_req_o}, 32'd0);
      chk("rst_busy regwe", {31'd0, regwe_o}, 32'd0);
      chk("rst_busy wdata", wdata_o, 32'd0);
      if (k == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    rst = 0;
    run_check("post_rst divu", 32'd14, 1'b1, 1'b1);

    // Randomized instructions against the model.
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      alusel = ($urandom_range(0, 3) == 0) ? 5'(12 + $urandom_range(0, 3))
                                           : 5'($urandom_range(0, 31));
      s1data = rnd_val(); s2data = rnd_val();
      reg1en = 1'($urandom_range(0, 1)); reg2en = 1'($urandom_range(0, 1));
      reg1addr = 5'($urandom_range(0, 3)); reg2addr = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); mem_regwe = 1'($urandom_range(0, 1));
      mem_wdata = rnd_val();
      wb_rd = 5'($urandom_range(0, 3)); wb_regwe = 1'($urandom_range(0, 1));
      wb_wdata = rnd_val();
      rd = 5'($urandom_range(0, 31)); regwe = 1'($urandom_range(0, 1));
      a = fwd(reg1en, reg1addr, s1data);
      b = fwd(reg2en, reg2addr, s2data);
      model(alusel, a, b, regwe, ew, ewe, mul);
      run_check($sformatf("rnd%0d op%0d", i, alusel), ew, ewe, mul);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
